mem_cmd_sequencer: RTL

//  Buffers byte-wide read/write requests from a valid/ready client and issues them one at a time
//  to the memory controller port (addr/wr_en/rd_en/wdata, returning rdata/busy/rd_rdy).
//  It sits directly upstream of the memory controller, in place of the testbench driver.

---
 rtl/mem_cmd_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_cmd_sequencer.sv
// mem_cmd_sequencer: queues client read/write commands and issues them one at a time to a
// memory controller, returning read data on a valid/ready port with a watchdog abort.
module mem_cmd_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_busy,
  input  logic              mem_rd_rdy,
  output logic              timeout_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT_WR, WAIT_RD} state_t;
  state_t            r_state, w_next;
  logic              r_init, r_we;
  logic [PW:0]       r_count;
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [TW-1:0]     r_timer;
  logic              r_q_we   [DEPTH];
  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [7:0]        r_q_data [DEPTH];
  logic              w_push, w_pop, w_go, w_cap, w_to, w_hit;
  assign cmd_ready   = r_init && (r_count != (PW+1)'(DEPTH));
  assign w_push      = cmd_valid && cmd_ready;
  assign w_pop       = r_state == ISSUE;
  // a read may only issue once the previous response has been taken
  assign w_go        = (r_count != '0) && !mem_busy && (r_q_we[r_rptr] || !rsp_valid);
  assign w_hit       = r_timer == TW'(TIMEOUT - 1);
  assign mem_wr_en   = w_pop && r_we;
  assign mem_rd_en   = w_pop && !r_we;
  assign timeout_err = w_to;
  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    w_to   = 1'b0;
    case (r_state)
      IDLE:    w_next = w_go ? ISSUE : IDLE;
      ISSUE:   w_next = ARM;
      ARM: begin
        w_cap  = !r_we && mem_rd_rdy;
        w_next = w_cap ? IDLE : (r_we ? WAIT_WR : WAIT_RD);
      end
      WAIT_WR: begin
        w_to   = mem_busy && w_hit;
        w_next = (!mem_busy || w_to) ? IDLE : WAIT_WR;
      end
      WAIT_RD: begin
        w_cap  = mem_rd_rdy;
        w_to   = !mem_rd_rdy && w_hit;
        w_next = (w_cap || w_to) ? IDLE : WAIT_RD;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_we[r_wptr]   <= cmd_we;
      r_q_addr[r_wptr] <= cmd_addr;
      r_q_data[r_wptr] <= cmd_wdata;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_init    <= 1'b0;
      r_we      <= 1'b0;
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_timer   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_init  <= 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (r_state == IDLE && w_go) begin
        r_we      <= r_q_we[r_rptr];
        mem_addr  <= r_q_addr[r_rptr];
        mem_wdata <= r_q_data[r_rptr];
      end
      r_timer <= w_pop ? '0 : (r_state inside {ARM, WAIT_WR, WAIT_RD}) ? r_timer + TW'(1) : r_timer;
      if (w_cap) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= mem_rdata;
      end else if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule
